fft_sdf_ctrl: RTL and testbench

FFT_SDF_CTRL -- requirements
Module: fft_sdf_ctrl

---
 rtl/fft_sdf_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fft_sdf_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sdf_ctrl.sv
// Sequencing controller for a radix-2 single-path delay-feedback FFT: butterfly selects, output framing, abort and frame count.
// Optional build macro FFT_SDF_CTRL_BITREV_EN: out_idx_o reports natural bin order (bit-reversed pipeline index).
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start_i with in_valid_i; ph held at 0, pipeline empty
// S_RUN   | accepting input samples; ph advances every cycle
// S_DRAIN | no input; pipeline flushes its last N-1 outputs via drain timer
module fft_sdf_ctrl #(
    parameter int N_LOG2          = 10,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       in_valid_i,
    output logic                       ready_o,
    output logic [N_LOG2-1:0]          sel_o,
    output logic                       out_valid_o,
    output logic [N_LOG2-1:0]          out_idx_o,
    output logic                       out_last_o,
    output logic                       err_o,
    output logic [FRAME_CNT_WIDTH-1:0] frames_o
);

    localparam logic [N_LOG2-1:0] PH_MAX    = '1;
    localparam logic [N_LOG2-1:0] PH_PENULT = {{(N_LOG2-1){1'b1}}, 1'b0};
    localparam logic [N_LOG2-1:0] PH_ONE    = N_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [N_LOG2-1:0]          ph_q, ph_d;
    logic [N_LOG2-1:0]          drain_cnt_q, drain_cnt_d;
    logic                       filled_q, filled_d;
    logic                       err_q, err_d;
    logic [FRAME_CNT_WIDTH-1:0] frames_q;
    logic [N_LOG2-1:0]          idx_nat;
    logic [N_LOG2-1:0]          sel_diff;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            drain_cnt_q <= '0;
            filled_q    <= 1'b0;
            err_q       <= 1'b0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            drain_cnt_q <= drain_cnt_d;
            filled_q    <= filled_d;
            err_q       <= err_d;
            if (out_last_o) begin
                frames_q <= frames_q + FRAME_CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        drain_cnt_d = drain_cnt_q;
        filled_d    = filled_q;
        err_d       = err_q;
        ready_o     = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_o  = 1'b1;
                ph_d     = '0;
                filled_d = 1'b0;
                if (start_i && in_valid_i) begin
                    state_d = S_RUN;
                    ph_d    = ph_q + PH_ONE;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                ready_o = (ph_q == PH_MAX);
                // A gap in the input stream corrupts the delay lines, so the frame is dropped outright.
                if (!in_valid_i) begin
                    state_d  = S_IDLE;
                    ph_d     = '0;
                    filled_d = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    out_valid_o = filled_q;
                    ph_d        = ph_q + PH_ONE;
                    if (ph_q == PH_PENULT) begin
                        filled_d = 1'b1;
                    end
                    if (ph_q == PH_MAX) begin
                        if (start_i) begin
                            err_d = 1'b0;
                        end else begin
                            state_d     = S_DRAIN;
                            drain_cnt_d = PH_PENULT;
                        end
                    end
                end
            end
            S_DRAIN: begin
                out_valid_o = filled_q;
                ph_d        = ph_q + PH_ONE;
                if (drain_cnt_q == '0) begin
                    state_d  = S_IDLE;
                    ph_d     = '0;
                    filled_d = 1'b0;
                end else begin
                    drain_cnt_d = drain_cnt_q - PH_ONE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                ph_d     = '0;
                filled_d = 1'b0;
            end
        endcase

        out_last_o = out_valid_o && (ph_q == PH_PENULT);
    end

    // Stage k sees the frame delayed by D_k = N - N/2^k; its select is the matching bit of the delayed phase.
    always_comb begin
        sel_o    = '0;
        sel_diff = '0;
        for (int k = 0; k < N_LOG2; k++) begin
            sel_diff = ph_q - N_LOG2'((1 << N_LOG2) - ((1 << N_LOG2) >> k));
            sel_o[k] = sel_diff[N_LOG2-1-k];
        end
    end

    assign idx_nat = ph_q + PH_ONE;

`ifdef FFT_SDF_CTRL_BITREV_EN
    logic [N_LOG2-1:0] idx_rev;

    always_comb begin
        idx_rev = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            idx_rev[i] = idx_nat[N_LOG2-1-i];
        end
    end

    assign out_idx_o = out_valid_o ? idx_rev : '0;
`else
    assign out_idx_o = out_valid_o ? idx_nat : '0;
`endif

    assign err_o    = err_q;
    assign frames_o = frames_q;

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// Self-checking bench for fft_sdf_ctrl at N_LOG2=4: scoreboard of expected outputs per accepted sample,
// plus per-cycle checks of ready, err, sel and idle output values.
module tb_fft_sdf_ctrl;

    localparam int NL = 4;
    localparam int N  = 16;
    localparam int FW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          in_valid_i;
    logic          ready_o;
    logic [NL-1:0] sel_o;
    logic          out_valid_o;
    logic [NL-1:0] out_idx_o;
    logic          out_last_o;
    logic          err_o;
    logic [FW-1:0] frames_o;

    fft_sdf_ctrl #(.N_LOG2(NL), .FRAME_CNT_WIDTH(FW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .ready_o     (ready_o),
        .sel_o       (sel_o),
        .out_valid_o (out_valid_o),
        .out_idx_o   (out_idx_o),
        .out_last_o  (out_last_o),
        .err_o       (err_o),
        .frames_o    (frames_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int cyc;
        int idx;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    int   tb_ph = 0;
    bit   exp_ready = 1'b1;
    bit   exp_err = 1'b0;
    int   exp_frames = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got=%0d want=%0d", tag, cyc, got, want);
        end
    endtask

    function automatic logic [NL-1:0] exp_sel(input int ph);
        int dk[4];
        logic [NL-1:0] r;
        int t;
        dk = '{0, 8, 12, 14};
        r = '0;
        for (int k = 0; k < NL; k++) begin
            t = (ph - dk[k] + N) % N;
            r[k] = ((t >> (NL - 1 - k)) & 1) != 0;
        end
        return r;
    endfunction

    function automatic int exp_idx(input int s);
        logic [NL-1:0] v;
        v = NL'(s);
`ifdef FFT_SDF_CTRL_BITREV_EN
        return int'({v[0], v[1], v[2], v[3]});
`else
        return int'(v);
`endif
    endfunction

    always @(negedge clk_i) begin
        if (mon_en) begin
            exp_t e;
            if (out_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexp_valid", 32'(out_valid_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_cyc", 32'(cyc), 32'(e.cyc));
                    chk("out_idx", 32'(out_idx_o), 32'(e.idx));
                    chk("out_last", 32'(out_last_o), 32'(e.last));
                end
            end else begin
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    chk("out_miss", 32'(out_valid_o), 32'd1);
                    void'(sb.pop_front());
                end
                chk("idx_idle", 32'(out_idx_o), 32'd0);
                chk("last_idle", 32'(out_last_o), 32'd0);
            end
            chk("ready", 32'(ready_o), 32'(exp_ready));
            chk("err", 32'(err_o), 32'(exp_err));
            chk("sel", 32'(sel_o), 32'(exp_sel(tb_ph)));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk_i);
        chk({tag, "_frames"}, 32'(frames_o), 32'(exp_frames));
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    endtask

    // nfr frames back-to-back; rst_at >= 0 pulses reset during that frame-relative cycle.
    task automatic run_frames(input int nfr, input int rst_at);
        int base;
        int total;
        int s;
        int c;
        exp_t e;
        base  = cyc;
        total = N * nfr;
        for (int j = 0; j < total; j++) begin
            s          = j % N;
            start_i    = (j == 0) || (j == 3) || (s == N - 1 && j / N < nfr - 1);
            in_valid_i = 1'b1;
            tb_ph      = s;
            exp_ready  = (j == 0) || (s == N - 1);
            if (j > 0) exp_err = 1'b0;
            if (rst_at < 0 || j + N - 1 <= rst_at) begin
                e.cyc  = base + j + N - 1;
                e.idx  = exp_idx(s);
                e.last = (s == N - 1);
                sb.push_back(e);
            end
            tick();
        end
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        for (int d = 0; d < N - 1; d++) begin
            c         = total + d;
            tb_ph     = d;
            exp_ready = 1'b0;
            if (c == rst_at) begin
                rst_i = 1'b1;
                tick();
                rst_i      = 1'b0;
                tb_ph      = 0;
                exp_ready  = 1'b1;
                exp_err    = 1'b0;
                exp_frames = 0;
                @(negedge clk_i);
                chk("rst_valid", 32'(out_valid_o), 32'd0);
                chk("rst_last", 32'(out_last_o), 32'd0);
                chk("rst_idx", 32'(out_idx_o), 32'd0);
                chk("rst_err", 32'(err_o), 32'd0);
                chk("rst_frames", 32'(frames_o), 32'd0);
                chk("rst_ready", 32'(ready_o), 32'd1);
                return;
            end
            tick();
        end
        tb_ph      = 0;
        exp_ready  = 1'b1;
        exp_frames = exp_frames + nfr;
        idle_check("frame_end");
    endtask

    initial begin
        rst_i      = 1'b1;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        repeat (3) tick();
        @(negedge clk_i);
        chk("init_ready", 32'(ready_o), 32'd1);
        chk("init_valid", 32'(out_valid_o), 32'd0);
        chk("init_last", 32'(out_last_o), 32'd0);
        chk("init_idx", 32'(out_idx_o), 32'd0);
        chk("init_err", 32'(err_o), 32'd0);
        chk("init_frames", 32'(frames_o), 32'd0);
        chk("init_sel", 32'(sel_o), 32'(exp_sel(0)));
        tick();
        rst_i  = 1'b0;
        mon_en = 1'b1;
        tick();

        // single frame with a stray start at cycle 3
        run_frames(1, -1);
        tick();

        // two frames back to back
        run_frames(2, -1);
        tick();

        // abort: in_valid drops at frame cycle 5
        for (int j = 0; j < 6; j++) begin
            start_i    = (j == 0);
            in_valid_i = (j < 5);
            tb_ph      = j;
            exp_ready  = (j == 0);
            tick();
        end
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        tb_ph      = 0;
        exp_ready  = 1'b1;
        exp_err    = 1'b1;
        @(negedge clk_i);
        chk("abort_err", 32'(err_o), 32'd1);
        chk("abort_valid", 32'(out_valid_o), 32'd0);
        chk("abort_frames", 32'(frames_o), 32'(exp_frames));
        repeat (3) tick();

        // next accepted frame clears err
        run_frames(1, -1);
        tick();

        // reset at frame cycle 20 (inside drain)
        run_frames(1, 20);
        tick();

        run_frames(1, -1);
        tick();

        chk("sb_left", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
